fir_coeff_loader: RTL and testbench

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

---
 rtl/fir_pkg.sv | 16 +
 rtl/coeff_bank_ram.sv | 35 +++
 rtl/fir_coeff_loader.sv | 130 +++++++++++++
 tb/tb_fir_coeff_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader: control states and address sizing.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_DISCARD   = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } fsm_state_t;

    // Tap-address width; a single-tap filter still needs a one-bit address.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/coeff_bank_ram.sv
// Two-bank coefficient store: simple dual-port RAM addressed by {bank, tap}.
// Registered read gives one cycle of latency; contents survive reset.
module coeff_bank_ram #(
    parameter int    DWIDTH    = 16,
    parameter int    AWIDTH    = 9,
    parameter string INIT_FILE = "none.mif"
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AWIDTH:0]   waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AWIDTH:0]   raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 * (2 ** AWIDTH);

    logic [DWIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DWIDTH-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    // Read port
    always_ff @(posedge clk_i) begin
        r_rdata <= r_mem[raddr_i];
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/fir_coeff_loader.sv
// Streams coefficient sets into the inactive bank of a ping-pong RAM and swaps
// banks only on a filter sample boundary; malformed sets raise a sticky error.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int    DWIDTH      = 16,
    parameter int    LEN         = 511,
    parameter string COEFFS_FILE = "none.mif",
    localparam int   AWIDTH      = addr_width(LEN)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              sample_tick_i,
    input  logic              coeff_valid_i,
    input  logic [DWIDTH-1:0] coeff_data_i,
    input  logic              coeff_last_i,
    output logic              coeff_ready_o,
    input  logic [AWIDTH-1:0] rdaddr_i,
    output logic [DWIDTH-1:0] rddata_o,
    output logic              bank_o,
    output logic              swap_o,
    output logic              err_o
);

    localparam logic [AWIDTH-1:0] LAST_K = AWIDTH'(LEN - 1);

    fsm_state_t        r_state;
    logic [AWIDTH-1:0] r_cnt;
    logic              r_bank;
    logic              r_swap;
    logic              r_err;
    logic              r_ready;

    logic              w_xfer;
    logic              w_loading;
    logic [AWIDTH-1:0] w_k;
    logic              w_at_end;
    logic              w_err_base;
    logic              w_we;
    logic [AWIDTH:0]   w_waddr;
    logic [AWIDTH:0]   w_raddr;

    // Transfer qualification and index of the word currently on the bus
    always_comb begin
        w_xfer     = coeff_valid_i & r_ready;
        w_loading  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
        w_k        = (r_state == ST_LOAD) ? r_cnt : '0;
        w_at_end   = (w_k == LAST_K);
        w_err_base = (r_state == ST_IDLE) ? 1'b0 : r_err;
        w_we       = w_xfer & w_loading & ~srst_i;
        w_waddr    = {~r_bank, w_k};
        w_raddr    = {r_bank, rdaddr_i};
    end

    // Control FSM with word counter, bank select and registered outputs
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bank  <= 1'b0;
            r_swap  <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_swap <= 1'b0;
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_xfer) begin
                        if (coeff_last_i && w_at_end) begin
                            r_state <= ST_WAIT_SWAP;
                            r_cnt   <= '0;
                            r_err   <= w_err_base;
                            r_ready <= 1'b0;
                        end else if (coeff_last_i) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_err   <= 1'b1;
                        end else if (w_at_end) begin
                            // Overlong set: swallow the rest up to its last word.
                            r_state <= ST_DISCARD;
                            r_cnt   <= '0;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                            r_cnt   <= w_k + AWIDTH'(1);
                            r_err   <= w_err_base;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (w_xfer && coeff_last_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_SWAP: begin
                    if (sample_tick_i) begin
                        r_state <= ST_IDLE;
                        r_bank  <= ~r_bank;
                        r_swap  <= 1'b1;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    coeff_bank_ram #(
        .DWIDTH    (DWIDTH),
        .AWIDTH    (AWIDTH),
        .INIT_FILE (COEFFS_FILE)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (w_we),
        .waddr_i (w_waddr),
        .wdata_i (coeff_data_i),
        .raddr_i (w_raddr),
        .rdata_o (rddata_o)
    );

    assign coeff_ready_o = r_ready;
    assign bank_o        = r_bank;
    assign swap_o        = r_swap;
    assign err_o         = r_err;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed self-checking bench for fir_coeff_loader with a 4-tap configuration.
module tb_fir_coeff_loader;

    localparam int DW  = 16;
    localparam int LEN = 4;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          srst_i;
    logic          sample_tick_i;
    logic          coeff_valid_i;
    logic [DW-1:0] coeff_data_i;
    logic          coeff_last_i;
    logic          coeff_ready_o;
    logic [AW-1:0] rdaddr_i;
    logic [DW-1:0] rddata_o;
    logic          bank_o;
    logic          swap_o;
    logic          err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_coeff_loader #(
        .DWIDTH      (DW),
        .LEN         (LEN),
        .COEFFS_FILE ("none.mif")
    ) dut (
        .clk_i         (clk),
        .srst_i        (srst_i),
        .sample_tick_i (sample_tick_i),
        .coeff_valid_i (coeff_valid_i),
        .coeff_data_i  (coeff_data_i),
        .coeff_last_i  (coeff_last_i),
        .coeff_ready_o (coeff_ready_o),
        .rdaddr_i      (rdaddr_i),
        .rddata_o      (rddata_o),
        .bank_o        (bank_o),
        .swap_o        (swap_o),
        .err_o         (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int guard;
        guard = 0;
        coeff_valid_i = 1'b1;
        coeff_data_i  = d;
        coeff_last_i  = l;
        while (coeff_ready_o !== 1'b1 && guard < 50) begin
            cyc();
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=ready_low expected=ready_high");
        end
        cyc();
        coeff_valid_i = 1'b0;
        coeff_last_i  = 1'b0;
    endtask

    task automatic tick();
        sample_tick_i = 1'b1;
        cyc();
        sample_tick_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
        rdaddr_i = a;
        cyc();
        chk(tag, {16'h0000, rddata_o}, {16'h0000, e});
    endtask

    initial begin
        srst_i        = 1'b1;
        sample_tick_i = 1'b0;
        coeff_valid_i = 1'b0;
        coeff_data_i  = 16'h0000;
        coeff_last_i  = 1'b0;
        rdaddr_i      = 2'd0;
        repeat (3) cyc();
        srst_i = 1'b0;
        chk("rst_ready", {31'd0, coeff_ready_o}, 32'd1);
        chk("rst_bank",  {31'd0, bank_o},        32'd0);
        chk("rst_swap",  {31'd0, swap_o},        32'd0);
        chk("rst_err",   {31'd0, err_o},         32'd0);

        // Basic load of {1,2,3,4}, tick ten cycles later
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        send(16'd3, 1'b0);
        send(16'd4, 1'b1);
        chk("wait_ready_low", {31'd0, coeff_ready_o}, 32'd0);
        repeat (10) cyc();
        chk("pre_tick_bank", {31'd0, bank_o}, 32'd0);
        chk("pre_tick_swap", {31'd0, swap_o}, 32'd0);
        tick();
        chk("swap_pulse", {31'd0, swap_o}, 32'd1);
        chk("swap_bank1", {31'd0, bank_o}, 32'd1);
        chk("swap_ready", {31'd0, coeff_ready_o}, 32'd1);
        cyc();
        chk("swap_once", {31'd0, swap_o}, 32'd0);
        rd("rd_b1_a0", 2'd0, 16'd1);
        rd("rd_b1_a1", 2'd1, 16'd2);
        rd("rd_b1_a2", 2'd2, 16'd3);
        rd("rd_b1_a3", 2'd3, 16'd4);

        // Short set: last on word 2 of 4
        send(16'd7, 1'b0);
        send(16'd8, 1'b1);
        chk("short_err",   {31'd0, err_o},         32'd1);
        chk("short_bank",  {31'd0, bank_o},        32'd1);
        chk("short_ready", {31'd0, coeff_ready_o}, 32'd1);
        tick();
        chk("short_noswap", {31'd0, swap_o}, 32'd0);
        chk("short_bank2",  {31'd0, bank_o}, 32'd1);

        // Long set: six words, last only on the sixth
        send(16'd11, 1'b0);
        chk("long_err_clear", {31'd0, err_o}, 32'd0);
        send(16'd12, 1'b0);
        send(16'd13, 1'b0);
        send(16'd14, 1'b0);
        chk("long_err_set", {31'd0, err_o}, 32'd1);
        send(16'd99, 1'b0);
        send(16'd98, 1'b1);
        chk("long_ready", {31'd0, coeff_ready_o}, 32'd1);
        tick();
        chk("long_noswap", {31'd0, swap_o}, 32'd0);
        chk("long_bank",   {31'd0, bank_o}, 32'd1);

        // Good set clears the error, includes a negative coefficient
        send(16'd10, 1'b0);
        send(16'hFFEC, 1'b0);
        send(16'd30, 1'b0);
        send(16'd40, 1'b1);
        chk("good_err_clear", {31'd0, err_o}, 32'd0);
        tick();
        chk("good_swap", {31'd0, swap_o}, 32'd1);
        chk("good_bank", {31'd0, bank_o}, 32'd0);
        rd("rd_b0_a0", 2'd0, 16'd10);
        rd("rd_b0_a1", 2'd1, 16'hFFEC);
        rd("rd_b0_a2", 2'd2, 16'd30);
        rd("rd_b0_a3", 2'd3, 16'd40);

        // Back-pressure: next set offered before the tick
        send(16'd5, 1'b0);
        send(16'd6, 1'b0);
        send(16'd7, 1'b0);
        send(16'd8, 1'b1);
        coeff_valid_i = 1'b1;
        coeff_data_i  = 16'd50;
        coeff_last_i  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_ready_low", {31'd0, coeff_ready_o}, 32'd0);
        end
        tick();
        chk("bp_swap",  {31'd0, swap_o},        32'd1);
        chk("bp_bank",  {31'd0, bank_o},        32'd1);
        chk("bp_ready", {31'd0, coeff_ready_o}, 32'd1);
        cyc();
        coeff_valid_i = 1'b0;
        send(16'd60, 1'b0);
        send(16'd70, 1'b0);
        send(16'd80, 1'b1);
        rd("bp_b1_a0", 2'd0, 16'd5);
        rd("bp_b1_a3", 2'd3, 16'd8);
        tick();
        chk("bp_bank0", {31'd0, bank_o}, 32'd0);
        rd("bp_b0_a0", 2'd0, 16'd50);
        rd("bp_b0_a1", 2'd1, 16'd60);
        rd("bp_b0_a2", 2'd2, 16'd70);
        rd("bp_b0_a3", 2'd3, 16'd80);

        // Reset mid-load after two words
        send(16'd1000, 1'b0);
        send(16'd2000, 1'b0);
        srst_i = 1'b1;
        cyc();
        srst_i = 1'b0;
        chk("mrst_bank",  {31'd0, bank_o},        32'd0);
        chk("mrst_err",   {31'd0, err_o},         32'd0);
        chk("mrst_ready", {31'd0, coeff_ready_o}, 32'd1);
        tick();
        chk("mrst_noswap", {31'd0, swap_o}, 32'd0);
        rd("mrst_a0", 2'd0, 16'd50);
        rd("mrst_a1", 2'd1, 16'd60);
        rd("mrst_a2", 2'd2, 16'd70);
        rd("mrst_a3", 2'd3, 16'd80);

        // Continuous read of address 2 across a swap
        send(16'd111, 1'b0);
        send(16'd222, 1'b0);
        send(16'd333, 1'b0);
        send(16'd444, 1'b1);
        rd("cr_before", 2'd2, 16'd70);
        tick();
        chk("cr_bank", {31'd0, bank_o}, 32'd1);
        chk("cr_old",  {16'h0000, rddata_o}, 32'd70);
        cyc();
        chk("cr_new",   {16'h0000, rddata_o}, 32'd333);
        chk("cr_swap0", {31'd0, swap_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
